mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the memory data width.
REQ-003 The ports SHALL be:
- clk  in  1  sole clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- mK_req  in  1  requester K (K=0,1) has an access pending.
- mK_we  in  1  requester K access is a write (1) or a read (0).
- mK_addr  in  ADDR_W  requester K address.
- mK_wdata  in  DATA_W  requester K write data.
- mK_gnt  out  1  single-cycle pulse: the access of requester K is issued.
- mK_done  out  1  single-cycle pulse: the access of requester K is complete.
- mK_rdata  out  DATA_W  read data for requester K; valid while mK_done=1 for a read.
- mem_en  out  1  memory strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous RAM output; valid one cycle after mem_en.
- busy  out  1  the state is not IDLE.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-005 Arbitration SHALL occur in IDLE and in RESP: if any mK_req=1, the block latches the winner id plus that requester's we/addr/wdata and goes to ACCESS; otherwise it goes to IDLE.
REQ-006 In ACCESS the block SHALL, for exactly one cycle:
- drive mem_en=1 and mem_we/mem_addr/mem_wdata from the latched copy;
- drive the winner's mK_gnt=1;
- go to RESP unconditionally.
REQ-007 In RESP the block SHALL drive the winner's mK_done=1 and set mK_rdata=mem_rdata for a read; mK_rdata SHALL be 0 for a write and at all other times.
REQ-008 Latency SHALL be fixed: the request is sampled at edge N, gnt is high in cycle N+1 and done is high in cycle N+2.
REQ-009 Back-to-back throughput SHALL be one access per 2 cycles, with no IDLE cycle between accesses while requests are pending.
REQ-010 A requester SHALL hold req/we/addr/wdata stable until it sees gnt, and on the edge ending the gnt cycle it SHALL drop req or present its next request; the block ignores requester inputs outside the arbitration states.
REQ-011 mem_en, mem_we, mem_addr and mem_wdata SHALL be 0 outside ACCESS.
REQ-012 At most one mK_gnt and at most one mK_done SHALL be high in any cycle.
REQ-013 A last_owner register SHALL update to the winner id at every arbitration win.
REQ-014 Simultaneous requests SHALL be resolved per REQ-019/REQ-020; a single requester SHALL always win.
REQ-015 Address and data SHALL pass through unmodified, with no wrap or width change; address FFFF is legal.

Reset
REQ-016 While reset=0 the block SHALL hold:
- state=IDLE and last_owner=1;
- every output at 0: gnt, done, rdata, mem_* and busy.
REQ-017 Reset asserted during ACCESS or RESP SHALL abandon the access: no done pulse is issued and the latched request is discarded.
REQ-018 The first arbitration after reset deassertion SHALL sample requests on the first rising clk edge at which reset=1.

Configuration
REQ-019 With macro ARB_ROUND_ROBIN_EN defined, a tie (both requesting) SHALL be won by the requester that is not last_owner.
REQ-020 Without ARB_ROUND_ROBIN_EN, requester 0 SHALL always win a tie (fixed priority); last_owner is still maintained but unused.

Verification
REQ-021 Single read: m0 reads address 0x0010 with RAM[0x0010]=0xA9 -> m0_gnt in cycle N+1 with mem_addr=0x0010 and mem_en=1; m0_done in cycle N+2 with m0_rdata=0xA9; busy=0 after.
REQ-022 Write then read: m1 writes 0x5A to 0xFFFF, then reads 0xFFFF -> mem_we=1 only in the first ACCESS; read returns 0x5A on m1_done; the second gnt occurs exactly 2 cycles after the first.
REQ-023 Tie, both builds: m0 and m1 request continuously for 4 accesses ->
- with ARB_ROUND_ROBIN_EN: grant order m0,m1,m0,m1;
- without it: m0,m0,m0,m0 and m1 is never granted while m0 requests.
REQ-024 Reset mid-access: reset driven to 0 during the ACCESS cycle of an m1 read -> all outputs read 0 immediately; no m1_done is issued; after release, the first tie is granted to m0.
REQ-025 Exclusivity check: random requests over 10000 cycles -> never two gnt or two done in the same cycle; every gnt is followed by exactly one matching done 1 cycle later; mem_en is high only in cycles where a gnt is high.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory and status signals of the two-master memory bus arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
`timescale 1ns/1ps
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_done, m0_rdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_done, m0_rdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter onto a synchronous single-port RAM: IDLE -> ACCESS -> RESP.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority to requester 0.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              last_owner;
  logic              owner;
  logic              lat_we;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic any_req;
  logic win;

  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    win     = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~last_owner;
`else
      win = 1'b0;
`endif
    end else begin
      win = bus.m1_req;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  // The mem_* registers double as the latched copy of the winning request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      owner       <= 1'b0;
      lat_we      <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          done <= '0;
          if (any_req) begin
            state       <= ACCESS;
            owner       <= win;
            last_owner  <= win;
            gnt         <= win ? 2'b10 : 2'b01;
            mem_en_q    <= 1'b1;
            mem_we_q    <= win ? bus.m1_we    : bus.m0_we;
            lat_we      <= win ? bus.m1_we    : bus.m0_we;
            mem_addr_q  <= win ? bus.m1_addr  : bus.m0_addr;
            mem_wdata_q <= win ? bus.m1_wdata : bus.m0_wdata;
          end else begin
            state       <= IDLE;
            gnt         <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end
        end
        ACCESS: begin
          state       <= RESP;
          gnt         <= '0;
          done        <= owner ? 2'b10 : 2'b01;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
        end
      endcase
    end
  end

  // RAM data arrives in the RESP cycle, so read data is steered, not registered.
  assign bus.m0_rdata = (done[0] && !lat_we) ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.m1_rdata = (done[1] && !lat_we) ? bus.mem_rdata : {DATA_W{1'b0}};

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_done   = done[0];
  assign bus.m1_done   = done[1];
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic against a schedule-based model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous RAM environment
  logic [7:0] ram [0:65535];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  // Reference model: per-cycle schedule of expected grants and completions
  logic [7:0]  mm [0:65535];
  int          edge_no = 0;
  int          next_arb = 0;
  bit          last_owner_m = 1'b1;
  bit          g_v [4];
  bit          g_id [4];
  bit          g_we [4];
  logic [15:0] g_addr [4];
  logic [7:0]  g_wd [4];
  bit          d_v [4];
  bit          d_id [4];
  logic [7:0]  d_rd [4];
  bit          hold [2];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          gq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    int s, s1;
    bit r0, r1, w, we;
    logic [15:0] a;
    logic [7:0] wd;
    s  = edge_no % 4;
    s1 = (edge_no + 1) % 4;
    r0 = bus.m0_req;
    r1 = bus.m1_req;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        g_v[i] = 1'b0;
        d_v[i] = 1'b0;
      end
      last_owner_m = 1'b1;
      next_arb = edge_no + 1;
    end else if (edge_no >= next_arb) begin
      if (r0 || r1) begin
        if (r0 && r1) w = RR ? !last_owner_m : 1'b0;
        else          w = r1;
        we = w ? bus.m1_we    : bus.m0_we;
        a  = w ? bus.m1_addr  : bus.m0_addr;
        wd = w ? bus.m1_wdata : bus.m0_wdata;
        g_v[s] = 1'b1; g_id[s] = w; g_we[s] = we; g_addr[s] = a; g_wd[s] = wd;
        d_v[s1] = 1'b1; d_id[s1] = w;
        d_rd[s1] = we ? 8'h00 : mm[a];
        if (we) mm[a] = wd;
        last_owner_m = w;
        hold[w] = 1'b0;
        next_arb = edge_no + 2;
      end else begin
        next_arb = edge_no + 1;
      end
    end
    edge_no++;
  endtask

  task automatic check_cycle();
    int s;
    logic [6:0] ef, of;
    s  = (edge_no - 1) % 4;
    ef = {g_v[s] && !g_id[s], g_v[s] && g_id[s], d_v[s] && !d_id[s], d_v[s] && d_id[s],
          g_v[s] || d_v[s], g_v[s], g_v[s] && g_we[s]};
    of = {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.busy, bus.mem_en, bus.mem_we};
    chk("ctrl{g0,g1,d0,d1,busy,en,we}", {25'd0, of}, {25'd0, ef});
    chk("mem_addr",  {16'd0, bus.mem_addr},  {16'd0, g_v[s] ? g_addr[s] : 16'h0000});
    chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, g_v[s] ? g_wd[s] : 8'h00});
    chk("m0_rdata",  {24'd0, bus.m0_rdata},  {24'd0, (d_v[s] && !d_id[s]) ? d_rd[s] : 8'h00});
    chk("m1_rdata",  {24'd0, bus.m1_rdata},  {24'd0, (d_v[s] &&  d_id[s]) ? d_rd[s] : 8'h00});
    if (bus.m0_gnt) gq.push_back(0);
    if (bus.m1_gnt) gq.push_back(1);
    g_v[s] = 1'b0;
    d_v[s] = 1'b0;
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drive(input int k, input bit r, input bit we, input logic [15:0] a, input logic [7:0] d);
    if (k == 0) begin
      bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
    hold[k] = r;
  endtask

  initial begin
    int t1;
    bit pg0, pg1, r, we;
    logic [15:0] a;
    logic [7:0] d;

    for (int i = 0; i < 65536; i++) begin
      logic [15:0] iv;
      iv = 16'(i);
      ram[i] = iv[7:0] ^ 8'h5C;
      mm[i]  = iv[7:0] ^ 8'h5C;
    end
    ram[16'h0010] = 8'hA9;
    mm[16'h0010]  = 8'hA9;
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);

    // Reset holds everything at zero
    repeat (3) step();
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b1;
    step();

    // Single read by m0
    drive(0, 1'b1, 1'b0, 16'h0010, 8'h00);
    step();
    chk("rd_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    chk("rd_mem_en", {31'd0, bus.mem_en}, 32'd1);
    chk("rd_mem_addr", {16'd0, bus.mem_addr}, 32'h0010);
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    chk("rd_m0_done", {31'd0, bus.m0_done}, 32'd1);
    chk("rd_m0_rdata", {24'd0, bus.m0_rdata}, 32'hA9);
    step();
    chk("rd_busy_after", {31'd0, bus.busy}, 32'd0);

    // m1 write then read at the top address
    drive(1, 1'b1, 1'b1, 16'hFFFF, 8'h5A);
    step();
    chk("wr_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
    chk("wr_mem_we", {31'd0, bus.mem_we}, 32'd1);
    t1 = cyc;
    drive(1, 1'b1, 1'b0, 16'hFFFF, 8'h00);
    step();
    step();
    chk("rd2_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
    chk("rd2_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("gnt_spacing", 32'(cyc - t1), 32'd2);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    chk("rd2_m1_done", {31'd0, bus.m1_done}, 32'd1);
    chk("rd2_m1_rdata", {24'd0, bus.m1_rdata}, 32'h5A);
    step();

    // Continuous tie for four accesses
    gq.delete();
    drive(0, 1'b1, 1'b0, 16'h0020, 8'h00);
    drive(1, 1'b1, 1'b0, 16'h0030, 8'h00);
    repeat (8) step();
    chk("tie_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) chk("tie_order", 32'(gq[i]), RR ? 32'(i % 2) : 32'd0);
    end
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (2) step();

    // Reset during the ACCESS cycle of an m1 read
    drive(1, 1'b1, 1'b0, 16'h0040, 8'h00);
    step();
    chk("rst_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    reset = 1'b0;
    #1;
    chk("rst_ctrl_zero", {25'd0, bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done,
                          bus.busy, bus.mem_en, bus.mem_we}, 32'd0);
    chk("rst_bus_zero", {bus.mem_addr, bus.mem_wdata, bus.m0_rdata | bus.m1_rdata}, 32'd0);
    step();
    chk("rst_no_done", {31'd0, bus.m1_done}, 32'd0);
    step();
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 16'h0050, 8'h00);
    drive(1, 1'b1, 1'b0, 16'h0060, 8'h00);
    step();
    chk("post_rst_tie_m0", {30'd0, bus.m0_gnt, bus.m1_gnt}, 32'd2);
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (2) step();

    // Random traffic
    pg0 = 1'b0;
    pg1 = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          r  = ($urandom_range(0, 2) != 0);
          we = 1'($urandom_range(0, 1));
          a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'(16'h00F0 + $urandom_range(0, 15));
          d  = 8'($urandom_range(0, 255));
          drive(k, r, we, a, d);
        end
      end
      step();
      chk("excl", {29'd0, bus.m0_gnt & bus.m1_gnt, bus.m0_done & bus.m1_done,
                   bus.mem_en & ~(bus.m0_gnt | bus.m1_gnt)}, 32'd0);
      chk("done_follows_gnt", {30'd0, bus.m0_done, bus.m1_done}, {30'd0, pg0, pg1});
      pg0 = bus.m0_gnt;
      pg1 = bus.m1_gnt;
    end
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
